// File: rtl/mgmt_irq_controller_pkg.sv
// Shared types for the management interrupt controller.
//   irqreg_t        : APB register map (byte addresses)
//   holdoff_state_t : irq holdoff FSM states (used only with MGMT_IRQ_HOLDOFF_EN)
//   rd_resp_t       : decoded read response (error flag + data)
package mgmt_irq_controller_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 10;

  typedef enum logic [9:0] {
    IRQ_RAW     = 10'h000,
    IRQ_PENDING = 10'h002,
    IRQ_ENABLE  = 10'h004,
    IRQ_MODE    = 10'h006,
    IRQ_ACTIVE  = 10'h008,
    IRQ_HOLDOFF = 10'h00a,
    IRQ_SET     = 10'h00c
  } irqreg_t;

  typedef enum logic [1:0] {
    HO_IDLE,
    HO_ASSERTED,
    HO_HOLDOFF
  } holdoff_state_t;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } rd_resp_t;

endpackage

// File: rtl/mgmt_irq_controller_source_cell.sv
// Per-source pending latch: level or rising-edge capture, W1S set, W1C clear.
// Set wins over clear in the same cycle, so a level source held high cannot be cleared.
//   pclk, preset_n : clock, synchronous active-low reset
//   irq_src        : source input (synchronous to pclk)
//   mode           : 1 = rising edge, 0 = level
//   w1s, w1c       : software set / clear strobes (one cycle)
//   pending        : registered pending flag
module mgmt_irq_source_cell (
  input  logic pclk,
  input  logic preset_n,
  input  logic irq_src,
  input  logic mode,
  input  logic w1s,
  input  logic w1c,
  output logic pending
);

  logic src_prev;
  logic set_c;

  // Source contribution depends on mode; software set always contributes.
  always_comb begin
    set_c = (mode ? (irq_src & ~src_prev) : irq_src) | w1s;
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      pending  <= 1'b0;
      src_prev <= 1'b0;
    end else begin
      pending  <= set_c | (pending & ~w1c);
      src_prev <= irq_src;
    end
  end

endmodule

// File: rtl/mgmt_irq_controller.sv
// APB completer that aggregates management interrupt sources onto a single irq.
// Optional macro MGMT_IRQ_HOLDOFF_EN adds a HOLDOFF register (0x0a) and an FSM that
// keeps irq low for HOLDOFF cycles after each deassertion.
//   pclk, preset_n                 : clock, synchronous active-low reset
//   psel, penable, pwrite, paddr,
//   pwdata, prdata, pready, pslverr: APB completer, 16-bit data, 10-bit address
//   irq_src[NUM_SRC]               : interrupt sources (synchronous to pclk)
//   irq                            : registered interrupt request, active high
module mgmt_irq_controller
  import mgmt_irq_controller_pkg::*;
#(
  parameter int unsigned NUM_SRC       = 16,
  parameter int unsigned HOLDOFF_WIDTH = 16,
  parameter int unsigned HOLDOFF_INIT  = 0
) (
  input  logic               pclk,
  input  logic               preset_n,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [ADDR_W-1:0]  paddr,
  input  logic [DATA_W-1:0]  pwdata,
  output logic [DATA_W-1:0]  prdata,
  output logic               pready,
  output logic               pslverr,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               irq
);

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] mode;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] w1c_c;
  logic [NUM_SRC-1:0] w1s_c;
  irqreg_t            reg_c;
  rd_resp_t           rd_c;
  logic               wr_ok_c;
  logic               setup_c;
  logic               wr_commit_c;

`ifdef MGMT_IRQ_HOLDOFF_EN
  logic [HOLDOFF_WIDTH-1:0] holdoff;
  logic [HOLDOFF_WIDTH-1:0] count;
  holdoff_state_t           state;
`endif

  assign reg_c       = irqreg_t'(paddr);
  assign active      = pending & enable;
  assign setup_c     = psel & ~penable;
  assign wr_commit_c = psel & penable & pready & pwrite & wr_ok_c;
  assign w1c_c       = (wr_commit_c && reg_c == IRQ_PENDING) ? NUM_SRC'(pwdata) : '0;
  assign w1s_c       = (wr_commit_c && reg_c == IRQ_SET)     ? NUM_SRC'(pwdata) : '0;

  // Address decode: read data/error and write legality for the current paddr.
  always_comb begin
    rd_c    = '{err: 1'b1, data: '0};
    wr_ok_c = 1'b0;
    if (!paddr[0]) begin
      case (reg_c)
        IRQ_RAW:     rd_c = '{err: 1'b0, data: DATA_W'(irq_src)};
        IRQ_PENDING: begin
          rd_c    = '{err: 1'b0, data: DATA_W'(pending)};
          wr_ok_c = 1'b1;
        end
        IRQ_ENABLE: begin
          rd_c    = '{err: 1'b0, data: DATA_W'(enable)};
          wr_ok_c = 1'b1;
        end
        IRQ_MODE: begin
          rd_c    = '{err: 1'b0, data: DATA_W'(mode)};
          wr_ok_c = 1'b1;
        end
        IRQ_ACTIVE:  rd_c = '{err: 1'b0, data: DATA_W'(active)};
`ifdef MGMT_IRQ_HOLDOFF_EN
        IRQ_HOLDOFF: begin
          rd_c    = '{err: 1'b0, data: DATA_W'(holdoff)};
          wr_ok_c = 1'b1;
        end
`endif
        IRQ_SET:     wr_ok_c = 1'b1;
        default:     rd_c = '{err: 1'b1, data: '0};
      endcase
    end
  end

  // Per-source pending cells.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    mgmt_irq_source_cell u_cell (
      .pclk     (pclk),
      .preset_n (preset_n),
      .irq_src  (irq_src[i]),
      .mode     (mode[i]),
      .w1s      (w1s_c[i]),
      .w1c      (w1c_c[i]),
      .pending  (pending[i])
    );
  end

  // APB response (captured in SETUP, presented in ACCESS) and rw registers.
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      enable  <= '0;
      mode    <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      pready  <= setup_c;
      pslverr <= setup_c & (pwrite ? ~wr_ok_c : rd_c.err);
      prdata  <= (setup_c && !pwrite) ? rd_c.data : '0;
      if (wr_commit_c && reg_c == IRQ_ENABLE) enable <= NUM_SRC'(pwdata);
      if (wr_commit_c && reg_c == IRQ_MODE)   mode   <= NUM_SRC'(pwdata);
    end
  end

`ifdef MGMT_IRQ_HOLDOFF_EN
  // Holdoff FSM: after irq drops, keep it low for HOLDOFF cycles before re-arming.
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      holdoff <= HOLDOFF_WIDTH'(HOLDOFF_INIT);
      count   <= '0;
      state   <= HO_IDLE;
      irq     <= 1'b0;
    end else begin
      if (wr_commit_c && reg_c == IRQ_HOLDOFF) holdoff <= HOLDOFF_WIDTH'(pwdata);
      case (state)
        HO_IDLE: begin
          if (|active) begin
            state <= HO_ASSERTED;
            irq   <= 1'b1;
          end
        end
        HO_ASSERTED: begin
          if (!(|active)) begin
            irq <= 1'b0;
            if (holdoff == '0) begin
              state <= HO_IDLE;
            end else begin
              count <= holdoff;
              state <= HO_HOLDOFF;
            end
          end
        end
        HO_HOLDOFF: begin
          irq   <= 1'b0;
          count <= count - HOLDOFF_WIDTH'(1);
          if (count == HOLDOFF_WIDTH'(1)) state <= HO_IDLE;
        end
        default: begin
          state <= HO_IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end
`else
  logic unused_holdoff_cfg;
  assign unused_holdoff_cfg = (HOLDOFF_WIDTH != 0) ^ (HOLDOFF_INIT != 0);

  // Plain aggregation: irq follows any enabled pending source.
  always_ff @(posedge pclk) begin
    if (!preset_n) irq <= 1'b0;
    else           irq <= |active;
  end
`endif

endmodule

// File: tb/tb_mgmt_irq_controller.sv
// Directed testbench for mgmt_irq_controller (16-source instance plus an 8-source instance
// sharing the same APB bus). Holdoff checks are compiled in with MGMT_IRQ_HOLDOFF_EN.
module tb_mgmt_irq_controller;

  logic        pclk     = 1'b0;
  logic        preset_n = 1'b0;
  logic        psel     = 1'b0;
  logic        penable  = 1'b0;
  logic        pwrite   = 1'b0;
  logic [9:0]  paddr    = '0;
  logic [15:0] pwdata   = '0;
  logic [15:0] irq_src  = '0;
  logic [15:0] prdata, prdata8;
  logic        pready, pready8, pslverr, pslverr8, irq, irq8;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] rd_data, rd_data8;
  logic        rd_err, wr_err;

  always #5 pclk = ~pclk;

  mgmt_irq_controller #(.NUM_SRC(16)) dut (
    .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .irq_src(irq_src), .irq(irq)
  );

  mgmt_irq_controller #(.NUM_SRC(8)) dut8 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata8), .pready(pready8), .pslverr(pslverr8),
    .irq_src(irq_src[7:0]), .irq(irq8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic apb_read(input logic [9:0] a);
    tick();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    tick();
    penable  = 1'b1;
    rd_data  = prdata;
    rd_data8 = prdata8;
    rd_err   = pslverr;
    check("pready in access", 32'(pready), 32'd1);
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  // pulse: sources forced high during the ACCESS cycle only (seen at the commit edge).
  task automatic apb_write(input logic [9:0] a, input logic [15:0] d, input logic [15:0] pulse);
    tick();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    tick();
    penable = 1'b1;
    irq_src = irq_src | pulse;
    wr_err  = pslverr;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    irq_src = irq_src & ~pulse;
  endtask

  // Reset lands on the edge that would have committed the write.
  task automatic apb_write_reset(input logic [9:0] a, input logic [15:0] d);
    tick();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    tick();
    penable  = 1'b1;
    preset_n = 1'b0;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    preset_n = 1'b1;
  endtask

  initial begin
    // ---- 1: reset state and decode errors
    tick(); tick();
    preset_n = 1'b1;
    tick();
    check("reset irq", 32'(irq), 32'd0);
    check("reset pready", 32'(pready), 32'd0);
    for (int a = 0; a <= 8; a += 2) begin
      apb_read(10'(a));
      check($sformatf("reset rd %0h data", a), 32'(rd_data), 32'd0);
      check($sformatf("reset rd %0h err", a), 32'(rd_err), 32'd0);
    end
    apb_read(10'h00e);
    check("unmapped err", 32'(rd_err), 32'd1);
    check("unmapped data", 32'(rd_data), 32'd0);
    apb_read(10'h001);
    check("misaligned err", 32'(rd_err), 32'd1);
    apb_read(10'h00c);
    check("read SET err", 32'(rd_err), 32'd1);
    check("read SET data", 32'(rd_data), 32'd0);
    apb_read(10'h00a);
`ifdef MGMT_IRQ_HOLDOFF_EN
    check("HOLDOFF reset err", 32'(rd_err), 32'd0);
    check("HOLDOFF reset data", 32'(rd_data), 32'd0);
`else
    check("HOLDOFF unmapped err", 32'(rd_err), 32'd1);
`endif
    apb_write(10'h000, 16'hffff, 16'h0);
    check("write RAW err", 32'(wr_err), 32'd1);
    irq_src = 16'h00a5;
    apb_read(10'h000);
    check("RAW", 32'(rd_data), 32'h00a5);
    check("RAW dut8", 32'(rd_data8), 32'h00a5);
    irq_src = 16'h0000;
    apb_write(10'h002, 16'hffff, 16'h0);
    apb_read(10'h002);
    check("PENDING cleared", 32'(rd_data), 32'd0);

    // ---- 2: level source, latency, W1C while high
    apb_write(10'h004, 16'h0001, 16'h0);
    apb_read(10'h004);
    check("ENABLE rb", 32'(rd_data), 32'h0001);
    irq_src = 16'h0001;
    tick();
    check("level irq N+1", 32'(irq), 32'd0);
    tick();
    check("level irq N+2", 32'(irq), 32'd1);
    apb_read(10'h002);
    check("level PENDING", 32'(rd_data), 32'h0001);
    apb_write(10'h002, 16'h0001, 16'h0);
    apb_read(10'h002);
    check("W1C while high", 32'(rd_data), 32'h0001);
    check("irq while high", 32'(irq), 32'd1);
    irq_src = 16'h0000;
    apb_write(10'h002, 16'h0001, 16'h0);
    check("irq at commit", 32'(irq), 32'd1);
    tick();
    check("irq after W1C", 32'(irq), 32'd0);

    // ---- 3: edge mode, set beats clear
    apb_write(10'h006, 16'h0002, 16'h0);
    apb_write(10'h004, 16'h0002, 16'h0);
    apb_read(10'h006);
    check("MODE rb", 32'(rd_data), 32'h0002);
    irq_src = 16'h0002;
    tick();
    irq_src = 16'h0000;
    tick();
    check("edge irq", 32'(irq), 32'd1);
    apb_read(10'h002);
    check("edge PENDING", 32'(rd_data), 32'h0002);
    apb_write(10'h002, 16'h0002, 16'h0002);
    apb_read(10'h002);
    check("set beats clear", 32'(rd_data), 32'h0002);
    check("irq held", 32'(irq), 32'd1);
    apb_write(10'h002, 16'h0002, 16'h0);
    tick();
    check("edge irq cleared", 32'(irq), 32'd0);
    apb_read(10'h002);
    check("edge PENDING cleared", 32'(rd_data), 32'd0);

    // ---- 4: software set, masking, NUM_SRC=8 bounds
    apb_write(10'h004, 16'h0000, 16'h0);
    apb_write(10'h00c, 16'h8000, 16'h0);
    apb_read(10'h002);
    check("SET PENDING", 32'(rd_data), 32'h8000);
    check("SET PENDING dut8", 32'(rd_data8), 32'd0);
    apb_read(10'h008);
    check("ACTIVE masked", 32'(rd_data), 32'd0);
    check("irq masked", 32'(irq), 32'd0);
    apb_write(10'h004, 16'h8000, 16'h0);
    check("irq at enable commit", 32'(irq), 32'd0);
    tick();
    check("irq after enable", 32'(irq), 32'd1);
    check("irq dut8", 32'(irq8), 32'd0);
    apb_read(10'h004);
    check("ENABLE dut8 upper", 32'(rd_data8), 32'd0);
    apb_read(10'h008);
    check("ACTIVE", 32'(rd_data), 32'h8000);

`ifdef MGMT_IRQ_HOLDOFF_EN
    // ---- 5: holdoff FSM
    apb_write(10'h002, 16'h8000, 16'h0);
    apb_write(10'h004, 16'h0002, 16'h0);
    apb_write(10'h00a, 16'h0004, 16'h0);
    apb_read(10'h00a);
    check("HOLDOFF rb", 32'(rd_data), 32'h0004);
    irq_src = 16'h0002;
    tick();
    irq_src = 16'h0000;
    tick();
    check("ho assert", 32'(irq), 32'd1);
    apb_write(10'h002, 16'h0002, 16'h0);
    tick();
    check("ho exit", 32'(irq), 32'd0);
    irq_src = 16'h0002;
    tick();
    irq_src = 16'h0000;
    check("ho cnt 1", 32'(irq), 32'd0);
    tick();
    check("ho cnt 2", 32'(irq), 32'd0);
    tick();
    check("ho cnt 3", 32'(irq), 32'd0);
    tick();
    check("ho cnt 4", 32'(irq), 32'd0);
    tick();
    check("ho reassert", 32'(irq), 32'd1);
    apb_write(10'h00a, 16'h0000, 16'h0);
    apb_write(10'h002, 16'h0002, 16'h0);
    tick();
    check("ho0 exit", 32'(irq), 32'd0);
    irq_src = 16'h0002;
    tick();
    irq_src = 16'h0000;
    check("ho0 latch", 32'(irq), 32'd0);
    tick();
    check("ho0 reassert", 32'(irq), 32'd1);
    // reset while counting down
    apb_write(10'h00a, 16'h0004, 16'h0);
    apb_write(10'h002, 16'h0002, 16'h0);
    tick();
    tick();
    preset_n = 1'b0;
    tick();
    preset_n = 1'b1;
    check("ho reset irq", 32'(irq), 32'd0);
    apb_read(10'h00a);
    check("ho reset HOLDOFF", 32'(rd_data), 32'd0);
    apb_write(10'h004, 16'h0002, 16'h0);
    apb_write(10'h00c, 16'h0002, 16'h0);
    check("ho post-reset idle", 32'(irq), 32'd0);
    tick();
    check("ho post-reset assert", 32'(irq), 32'd1);
`endif

    // ---- 6: reset during ACCESS discards the write
    apb_write_reset(10'h002, 16'hffff);
    check("rst irq", 32'(irq), 32'd0);
    check("rst pready", 32'(pready), 32'd0);
    apb_read(10'h002);
    check("rst PENDING", 32'(rd_data), 32'd0);
    apb_read(10'h004);
    check("rst ENABLE", 32'(rd_data), 32'd0);
    apb_write_reset(10'h00c, 16'h0100);
    apb_read(10'h002);
    check("aborted SET", 32'(rd_data), 32'd0);
    apb_write(10'h00c, 16'h0100, 16'h0);
    apb_read(10'h002);
    check("SET after reset", 32'(rd_data), 32'h0100);
    check("SET after reset dut8", 32'(rd_data8), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
